// File: rtl/shift_exec_stage_pkg.sv
// Shared ALU definitions for the shift execution stage: data width, shift-amount
// width, shift opcodes and a bit-reversal helper.
package shift_exec_stage_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } sh_op_e;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = a[WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_stage_shift_core.sv
// Combinational shift core: two left shifters plus bit-reversal wiring give
// SLL, SRL, SRA and ROL.
module left_shifter
  import shift_exec_stage_pkg::*;
(
  input  logic [WIDTH-1:0]   i_a,
  input  logic [SHAMT_W-1:0] i_s,
  output logic [WIDTH-1:0]   o_z
);
  assign o_z = i_a << i_s;
endmodule

module shift_core
  import shift_exec_stage_pkg::*;
(
  input  logic [WIDTH-1:0]   i_x,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  sh_op_e             i_op,
  output logic [WIDTH-1:0]   o_z
);
  logic [WIDTH-1:0]   w_x_rev;
  logic [WIDTH-1:0]   w_a_in, w_a_out;
  logic [WIDTH-1:0]   w_b_in, w_b_out;
  logic [SHAMT_W-1:0] w_b_s;
  logic [WIDTH-1:0]   w_srl, w_mask, w_sra, w_rol;

  assign w_x_rev = bit_rev(i_x);

  // Shifter A: sll(x,s) for SLL/ROL, sll(rev(x),s) for SRL/SRA.
  assign w_a_in = (i_op == SH_SLL || i_op == SH_ROL) ? i_x : w_x_rev;

  // Shifter B: SRA fill mask source, or the wrap-around half of ROL using
  // amount (32-s) mod 32; the s==0 case is bypassed below.
  assign w_b_in = (i_op == SH_ROL) ? w_x_rev : '1;
  assign w_b_s  = (i_op == SH_ROL) ? (~i_shamt + 1'b1) : i_shamt;

  left_shifter u_shl_a (.i_a(w_a_in), .i_s(i_shamt), .o_z(w_a_out));
  left_shifter u_shl_b (.i_a(w_b_in), .i_s(w_b_s),   .o_z(w_b_out));

  assign w_srl  = bit_rev(w_a_out);
  assign w_mask = bit_rev(w_b_out);
  assign w_sra  = w_srl | (i_x[WIDTH-1] ? ~w_mask : '0);
  assign w_rol  = (i_shamt == '0) ? i_x : (w_a_out | bit_rev(w_b_out));

  always_comb begin
    // NOTE: default assignment first so no path leaves o_z unassigned (no latch).
    o_z = w_a_out;
    case (i_op)
      SH_SLL: o_z = w_a_out;
      SH_SRL: o_z = w_srl;
      SH_SRA: o_z = w_sra;
      SH_ROL: o_z = w_rol;
      default: o_z = w_a_out;
    endcase
  end
endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execution pipeline: operand capture, registered result with
// backpressure, and a saturating completed-operation counter.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_z,
  output logic               out_zero,
  output logic [CNT_W-1:0]   op_count
);
  logic               r_s1_valid, r_s2_valid;
  logic [WIDTH-1:0]   r_x, r_z;
  logic [SHAMT_W-1:0] r_shamt;
  sh_op_e             r_op;
  logic               r_zero;
  logic [CNT_W-1:0]   r_count;

  logic             w_s2_free, w_s1_adv, w_in_hs, w_out_hs;
  logic [WIDTH-1:0] w_result;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_s2_valid && out_ready;

  shift_core u_core (.i_x(r_x), .i_shamt(r_shamt), .i_op(r_op), .o_z(w_result));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_x        <= '0;
      r_shamt    <= '0;
      r_op       <= SH_SLL;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_x        <= in_x;
      r_shamt    <= in_shamt;
      r_op       <= sh_op_e'(in_op);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_zero     <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_z        <= w_result;
      r_zero     <= (w_result == '0);
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_count <= '0;
    else if (w_out_hs && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign out_valid = r_s2_valid;
  assign out_z     = r_z;
  assign out_zero  = r_zero;
  assign op_count  = r_count;
endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: driver pushes reference results on
// input handshakes, an independent monitor pops and compares on output handshakes.
module tb_shift_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_z;
  logic        out_zero;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_acc  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  shift_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_zero(out_zero), .op_count(op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written from the operation definitions, not the datapath.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                            input logic [4:0] s);
    logic [63:0] dbl;
    case (op)
      2'b00: return x << s;
      2'b01: return x >> s;
      2'b10: return $unsigned($signed(x) >>> s);
      default: begin
        dbl = {x, x} << s;
        return dbl[63:32];
      end
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] x,
                       input logic [4:0] s, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = v; in_op = op; in_x = x; in_shamt = s; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(ref_shift(op, x, s));
      n_acc++;
    end
    @(posedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [4:0] s);
    logic acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) drive(1'b1, op, x, s, 1'b1, acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, $urandom, 5'd0, ordy, acc);
  endtask

  task automatic drain;
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      idle(1, 1'b1);
      k++;
    end
    idle(2, 1'b1);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: compares every output handshake against the scoreboard front.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_z, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("out_z", out_z, e);
          check("out_zero", {31'd0, out_zero}, {31'd0, e == 32'd0});
          check("op_count_run", {16'd0, op_count}, n_out);
        end
        n_out++;
      end
    end
  end

  initial begin
    logic acc;
    int accepted;
    int cyc;
    logic [31:0] held_z;

    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_z", out_z, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First operation and two-cycle latency.
    send(2'b00, 32'h0000_0001, 5'd31);
    @(negedge clk); in_valid = 1'b0; #1;
    check("latency_n1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("latency_n2", {31'd0, out_valid}, 32'd1);
    check("first_z", out_z, 32'h8000_0000);
    @(negedge clk); #1;
    check("first_count", {16'd0, op_count}, 32'd1);

    // Directed corner values, with constants from the operation definitions.
    check("ref_sra", ref_shift(2'b10, 32'h8000_0000, 5'd4), 32'hF800_0000);
    send(2'b10, 32'h8000_0000, 5'd4);
    send(2'b01, 32'h8000_0000, 5'd4);
    send(2'b11, 32'h8000_0001, 5'd1);
    send(2'b11, 32'hDEAD_BEEF, 5'd0);
    send(2'b00, 32'h0000_0001, 5'd0);
    send(2'b01, 32'h0000_0001, 5'd1);
    send(2'b10, 32'h7FFF_FFFF, 5'd31);
    send(2'b11, 32'h1234_5678, 5'd31);
    drain();

    // Backpressure: only two operations fit with the output stalled.
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hA5A5_0000 + i, 5'(i + 3), 1'b0, acc);
      if (acc) accepted++;
    end
    check("bp_accepts", accepted, 32'd2);
    @(negedge clk); #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    held_z = out_z;
    in_x = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk); #1;
    check("bp_hold_z", out_z, held_z);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    cyc = 0;
    while (accepted < 4 && cyc < 50) begin
      drive(1'b1, 2'(accepted), 32'hA5A5_0000 + accepted, 5'(accepted + 3), 1'b1, acc);
      if (acc) accepted++;
      cyc++;
    end
    check("bp_total", accepted, 32'd4);
    drain();
    check("bp_count", {16'd0, op_count}, n_acc);

    // Random traffic with random valid/ready.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 5'($urandom),
            $urandom_range(0, 3) != 0, acc);
      if (acc) accepted++;
      cyc++;
    end
    check("rand_accepted", accepted, 32'd1000);
    drain();
    check("rand_count", {16'd0, op_count}, n_acc);

    // Reset with both stages full.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, $urandom, 5'($urandom), 1'b0, acc);
    @(negedge clk); #1;
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_z", out_z, 32'd0);
    check("mid_rst_zero", {31'd0, out_zero}, 32'd0);
    check("mid_rst_count", {16'd0, op_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    n_out = 0;
    n_acc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    send(2'b01, 32'hF000_0000, 5'd28);
    drain();
    check("post_rst_count", {16'd0, op_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Pipelined shift execution stage wrapping the combinational left shifter. It captures an operand word, shift amount and shift opcode through a valid/ready handshake, and computes SLL, SRL, SRA or ROL in a registered compute stage. It presents the registered result downstream with backpressure. It sits between the ALU operand-select logic (upstream) and the ALU result mux / writeback register (downstream).

## Interface
- `WIDTH`, 32: data width; only 32 is supported, since the shift amount is fixed at 5 bits.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  stage 1 can accept this cycle.
- `in_x`  in  32  operand.
- `in_shamt`  in  5  shift amount, 0..31.
- `in_op`  in  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream accepts.
- `out_z`  out  32  result.
- `out_zero`  out  1  result equals 0.
- `op_count`  out  `CNT_W`  number of completed output handshakes; saturates at all-ones.

## Operation
- Stage 1 (S1): registers `x`, `shamt`, `op` and `s1_valid`. It loads on an input handshake, i.e. `in_valid && in_ready`.
- Stage 2 (S2): registers `z`, `zero` and `s2_valid`. It loads the combinational result computed from S1 when S1 advances.
- Advance rules:
  - `s2_free = !s2_valid || out_ready`
  - `s1_adv = s1_valid && s2_free`
  - `in_ready = !s1_valid || s2_free` (combinational)
- Same-cycle updates: if S1 advances with no new input handshake, `s1_valid` is cleared. If S2 drains with no S1 advance, `s2_valid` is cleared.
- Result computation from the S1 registers, with `s` = `shamt`:
  - SLL: `x << s`, taken from the left-shifter instance.
  - SRL: `rev(sll(rev(x), s))`, where `rev` is bit reversal.
  - SRA: the SRL result, with the top `s` bits forced to `x[31]`. The fill mask is `rev(sll(32'hFFFFFFFF, s))`.
  - ROL: `sll(x, s) | srl(x, 32-s)`. When `s==0` the result is `x`; the 32-bit shift must not be performed.
- `out_zero` is registered alongside `z` in S2, as `(result == 0)`.
- `op_count` increments by 1 on each `out_valid && out_ready`. It holds at `2^CNT_W-1` and does not wrap.

## Timing
- Reset (asynchronous, `rst_n` low) clears:
  - `s1_valid = 0`, `s2_valid = 0`
  - `out_valid = 0`, `out_z = 0`, `out_zero = 0`, `op_count = 0`
  - S1 data registers to 0
- Consequently `in_ready = 1` while in reset and immediately after reset.
- Latency: input handshake on cycle N gives `out_valid` on cycle N+2. Throughput is 1 op/cycle when `out_ready` is held high.
- Backpressure:
  - `out_ready = 0` with S2 full holds `out_z` / `out_zero` stable.
  - S1 then also holds; `in_ready` falls only when both stages are full.
- Simultaneous events: a drain of S2, an advance of S1 and a load of S1 in the same cycle are all legal and lose no operation.
- Upstream data is sampled only on a handshake. Changes to `in_x` while `in_ready = 0` have no effect.
- Reset asserted mid-operation discards both in-flight operations. No partial output is produced.
- `out_valid` must never deassert without a handshake, except on reset.

## Structure
- Shared ALU package holds:
  - the opcode constants `SH_SLL=2'b00`, `SH_SRL=2'b01`, `SH_SRA=2'b10`, `SH_ROL=2'b11`
  - `WIDTH` and a 5-bit shift-amount constant.
- Sub-module: `shift_core`. This is a combinational block containing the two existing left-shifter instances, the bit-reversal wiring and the opcode result mux.
- `shift_exec_stage` itself holds only the pipeline registers, handshake logic and counter.

## Test plan
- Reset, then send SLL with `x=32'h0000_0001`, `s=31`, `out_ready=1` -> `out_valid` 2 cycles later, `out_z=32'h8000_0000`, `out_zero=0`, `op_count=1`.
- Send SRA `x=32'h8000_0000`, `s=4` -> `32'hF800_0000`. Send SRL with the same operands -> `32'h0800_0000`. Send ROL `x=32'h8000_0001`, `s=1` -> `32'h0000_0003`.
- Send ROL `x=32'hDEAD_BEEF`, `s=0` -> `32'hDEAD_BEEF`. Send SLL `x=32'h1`, `s=0` -> `32'h1`. Send SRL `x=32'h1`, `s=1` -> `32'h0`, `out_zero=1`.
- Backpressure:
  - Stream 4 ops with `out_ready=0` -> `in_ready` falls after 2 accepts.
  - Raise `out_ready` -> results emerge in order, none dropped or duplicated, `op_count=4`.
- Stream 1000 random ops with random `in_valid` / `out_ready` -> scoreboard matches a reference shift model, and `op_count` equals the number of handshakes.
- Assert `rst_n` low mid-stream with both stages full -> outputs go to reset values in the same cycle. After release, no stale result appears.
